// File: rtl/shift_unit.sv
// ---------------------------------------------------------------------------
// shift_unit
//
// Multi-cycle shift/rotate unit for the datapath ALU. An operation is
// accepted with a start pulse while idle, then executes one 1-bit step per
// clock on an internal working register. When the step counter reaches zero
// the working register is copied to the result, the CVNZ condition codes are
// registered, and a single-cycle done pulse is produced. Result and flags
// are held until the next operation completes.
//
// Parameters
//   OP_SIZE  operand/result width in bits (>= 2)
//   AMT_W    width of the shift-amount port (amount 0 .. 2**AMT_W-1)
//
// Ports
//   clk    in   system clock, rising-edge active
//   rst    in   asynchronous, active-high reset
//   start  in   operation request, sampled on a rising edge while idle
//   mode   in   000 SHL, 001 SHR, 010 ASR, 011 ROL, 100 ROR, 101-111 reserved
//   amt    in   number of 1-bit steps to perform
//   a      in   operand
//   r      out  result (registered)
//   ccr    out  condition codes {C,V,N,Z} (registered)
//   busy   out  high while an operation is in progress
//   done   out  single-cycle pulse when r/ccr have been updated
// ---------------------------------------------------------------------------
module shift_unit #(
    parameter int OP_SIZE = 4,
    parameter int AMT_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         mode,
    input  logic [AMT_W-1:0]   amt,
    input  logic [OP_SIZE-1:0] a,
    output logic [OP_SIZE-1:0] r,
    output logic [3:0]         ccr,
    output logic               busy,
    output logic               done
);

    localparam int MSB = OP_SIZE - 1;

    localparam logic [2:0] MODE_SHL = 3'b000;
    localparam logic [2:0] MODE_SHR = 3'b001;
    localparam logic [2:0] MODE_ASR = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [OP_SIZE-1:0] work_q,  work_d;   // value being shifted
    logic [AMT_W-1:0]   cnt_q,   cnt_d;    // steps still to perform
    logic [2:0]         mode_q,  mode_d;   // mode latched at start
    logic               c_q,     c_d;      // last bit shifted/rotated out
    logic               v_q,     v_d;      // sticky "MSB changed" for SHL
    logic [OP_SIZE-1:0] r_q,     r_d;
    logic [3:0]         ccr_q,   ccr_d;
    logic               done_q,  done_d;

    // ------------------------------------------------------------------
    // One 1-bit step of the working register for the latched mode.
    // ------------------------------------------------------------------
    logic [OP_SIZE-1:0] step_val;
    logic               step_out;

    // NOTE: every signal written in an always_comb block gets a default at
    // the top; a path that leaves one unassigned would infer a latch.
    always_comb begin
        step_val = work_q;
        step_out = 1'b0;
        case (mode_q)
            MODE_SHL: begin
                step_val = {work_q[MSB-1:0], 1'b0};
                step_out = work_q[MSB];
            end
            MODE_SHR: begin
                step_val = {1'b0, work_q[MSB:1]};
                step_out = work_q[0];
            end
            MODE_ASR: begin
                step_val = {work_q[MSB], work_q[MSB:1]};
                step_out = work_q[0];
            end
            MODE_ROL: begin
                step_val = {work_q[MSB-1:0], work_q[MSB]};
                step_out = work_q[MSB];
            end
            MODE_ROR: begin
                step_val = {work_q[0], work_q[MSB:1]};
                step_out = work_q[0];
            end
            default: begin
                // Reserved modes load a zero step count, so no step is ever
                // taken; the working register simply holds.
                step_val = work_q;
                step_out = 1'b0;
            end
        endcase
    end

    // Reserved modes behave as a zero-length operation.
    logic mode_reserved;
    assign mode_reserved = (mode > MODE_ROR);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        c_d     = c_q;
        v_d     = v_q;
        r_d     = r_q;
        ccr_d   = ccr_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Sampling happens only here, so start while busy is ignored
                // and later input changes cannot disturb a running operation.
                if (start) begin
                    work_d  = a;
                    mode_d  = mode;
                    cnt_d   = mode_reserved ? '0 : amt;
                    c_d     = 1'b0;
                    v_d     = 1'b0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (cnt_q != '0) begin
                    work_d = step_val;
                    cnt_d  = cnt_q - CNT_ONE;
                    c_d    = step_out;
                    // V records whether the sign bit ever moved during a
                    // left shift; it stays set once any step flips it.
                    if ((mode_q == MODE_SHL) && (step_val[MSB] != work_q[MSB])) begin
                        v_d = 1'b1;
                    end
                end else begin
                    r_d     = work_q;
                    ccr_d   = {c_q, v_q, work_q[MSB], (work_q == '0)};
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the pre-edge values regardless of statement order.
    // NOTE: every register is reset, including the working register and
    // counter, so an aborted operation leaves no residue behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_SHL;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            r_q     <= '0;
            ccr_q   <= 4'b0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            c_q     <= c_d;
            v_q     <= v_d;
            r_q     <= r_d;
            ccr_q   <= ccr_d;
            done_q  <= done_d;
        end
    end

    // busy is decoded straight from the state register, so it is glitch-free
    // and drops on the same edge that raises done.
    assign busy = (state_q == ST_RUN);
    assign done = done_q;
    assign r    = r_q;
    assign ccr  = ccr_q;

    // ------------------------------------------------------------------
    // Handshake invariants
    // ------------------------------------------------------------------
    busy_done_exclusive: assert property (
        @(posedge clk) disable iff (rst) !(busy && done)
    );

    done_single_pulse: assert property (
        @(posedge clk) disable iff (rst) done |=> !done
    );

endmodule
